// File: rtl/mac_result_drain_pkg.sv
// Shared constants for the MAC result drain: precision modes, lane geometry
// and drain FSM states.
package mac_result_drain_pkg;

   localparam int IN_W      = 128;
   localparam int OUT_W     = 20;
   localparam int CNT_W     = 16;

   localparam int LANE_W_2B = 8;
   localparam int LANE_W_4B = 12;
   localparam int LANE_W_8B = 20;

   localparam int LANES_2B  = 16;
   localparam int LANES_4B  = 4;
   localparam int LANES_8B  = 1;

   typedef enum logic [1:0] {
      MODE_2B  = 2'b00,
      MODE_4B  = 2'b01,
      MODE_8B  = 2'b10,
      MODE_ILL = 2'b11
   } mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_e;

   // Index of the final lane for a given precision mode.
   function automatic logic [3:0] last_lane(input logic [1:0] m);
      case (m)
         MODE_2B: last_lane = 4'(LANES_2B - 1);
         MODE_4B: last_lane = 4'(LANES_4B - 1);
         default: last_lane = 4'(LANES_8B - 1);
      endcase
   endfunction

endpackage

// File: rtl/mac_result_drain_lane_select.sv
// Combinational lane picker: extracts lane k of the captured accumulator word
// for the current precision and sign-extends it to the output width.
module rfu_lane_select
   import mac_result_drain_pkg::*;
(
   input  logic [IN_W-1:0]  data,
   input  logic [1:0]       mode,
   input  logic [3:0]       lane,
   output logic [OUT_W-1:0] value
);

   logic [6:0]           base_2b;
   logic [6:0]           base_4b;
   logic [LANE_W_2B-1:0] lane_2b;
   logic [LANE_W_4B-1:0] lane_4b;

   always_comb begin
      base_2b = {lane, 3'b000};
      base_4b = {5'b00000, lane[1:0]} * 7'd12;
      lane_2b = data[base_2b +: LANE_W_2B];
      lane_4b = data[base_4b +: LANE_W_4B];
      case (mode)
         MODE_2B: value = {{(OUT_W - LANE_W_2B){lane_2b[LANE_W_2B-1]}}, lane_2b};
         MODE_4B: value = {{(OUT_W - LANE_W_4B){lane_4b[LANE_W_4B-1]}}, lane_4b};
         MODE_8B: value = data[LANE_W_8B-1:0];
         default: value = '0;
      endcase
   end

endmodule

// File: rtl/mac_result_drain.sv
// Accepts one packed accumulator result at a time and streams its lanes out,
// one sign-extended lane per handshake, in ascending lane order.
module mac_result_drain
   import mac_result_drain_pkg::*;
(
   input  logic         clk,
   input  logic         nrst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [1:0]   mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [19:0]  out_data,
   output logic [3:0]   out_lane,
   output logic         out_last,
   output logic         err_mode,
   output logic [15:0]  result_count
);

   state_e            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [3:0]        lane_q, lane_d;
   logic [IN_W-1:0]   data_q, data_d;
   logic [1:0]        mode_q, mode_d;
   logic              err_mode_q, err_mode_d;
   logic [CNT_W-1:0]  result_count_q, result_count_d;

   logic              accept;
   logic              lane_hs;
   logic              is_last;
   logic [OUT_W-1:0]  lane_val;

   assign accept  = in_valid && in_ready_q;
   assign lane_hs = out_valid_q && out_ready;
   assign is_last = (lane_q == last_lane(mode_q));

   rfu_lane_select u_lane_select (
      .data  (data_q),
      .mode  (mode_q),
      .lane  (lane_q),
      .value (lane_val)
   );

   always_comb begin
      state_d        = state_q;
      in_ready_d     = in_ready_q;
      out_valid_d    = out_valid_q;
      lane_d         = lane_q;
      data_d         = data_q;
      mode_d         = mode_q;
      err_mode_d     = 1'b0;
      result_count_d = result_count_q;
      case (state_q)
         ST_IDLE: begin
            // in_ready rises on the first edge out of reset and stays up in IDLE
            in_ready_d = 1'b1;
            if (accept) begin
               data_d = in_data;
               mode_d = mode;
               if (mode == MODE_ILL) begin
                  err_mode_d = 1'b1;
               end else begin
                  state_d        = ST_DRAIN;
                  in_ready_d     = 1'b0;
                  out_valid_d    = 1'b1;
                  lane_d         = 4'd0;
                  result_count_d = result_count_q + 16'd1;
               end
            end
         end
         ST_DRAIN: begin
            if (lane_hs) begin
               if (is_last) begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b0;
                  in_ready_d  = 1'b1;
                  lane_d      = 4'd0;
               end else begin
                  lane_d = lane_q + 4'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q        <= ST_IDLE;
         in_ready_q     <= 1'b0;
         out_valid_q    <= 1'b0;
         lane_q         <= 4'd0;
         data_q         <= '0;
         mode_q         <= 2'b00;
         err_mode_q     <= 1'b0;
         result_count_q <= '0;
      end else begin
         state_q        <= state_d;
         in_ready_q     <= in_ready_d;
         out_valid_q    <= out_valid_d;
         lane_q         <= lane_d;
         data_q         <= data_d;
         mode_q         <= mode_d;
         err_mode_q     <= err_mode_d;
         result_count_q <= result_count_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_data     = out_valid_q ? lane_val : '0;
   assign out_lane     = lane_q;
   assign out_last     = out_valid_q && is_last;
   assign err_mode     = err_mode_q;
   assign result_count = result_count_q;

endmodule

// File: doc/mac_result_drain.md
MAC_RESULT_DRAIN -- requirements
Module: mac_result_drain

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset; clock `clk`, reset `nrst`.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- nrst  in  1  async active-low reset
- in_valid  in  1  producer result valid
- in_ready  out  1  drain accepts result
- in_data  in  128  packed accumulator result
- mode  in  2  precision of in_data: 00=2bx2b, 01=4bx4b, 10=8bx8b, 11=illegal
- out_valid  out  1  lane valid
- out_ready  in  1  downstream accepts lane
- out_data  out  20  signed lane value, sign-extended
- out_lane  out  4  lane index of out_data
- out_last  out  1  final lane of current result
- err_mode  out  1  one-cycle pulse: illegal mode dropped
- result_count  out  16  legal results accepted

Function
REQ-003 SHALL use states IDLE and DRAIN.
REQ-004 SHALL drive in_ready high only in IDLE; in_ready is registered.
REQ-005 SHALL accept a result on a rising edge where in_valid && in_ready.
- Capture in_data and mode into internal registers on that edge.
REQ-006 SHALL ignore in_data/mode changes after accept until the next accept.
REQ-007 On accept with legal mode, SHALL enter DRAIN, deassert in_ready, and assert out_valid on the same edge; lane 0 is visible the cycle after accept.
REQ-008 SHALL unpack the captured result as follows:
- mode 00: 16 lanes of 8b at bits [8k+7:8k]
- mode 01: 4 lanes of 12b at bits [12k+11:12k]
- mode 10: 1 lane of 20b at bits [19:0]
REQ-009 SHALL sign-extend each lane from its MSB to 20 bits on out_data.
REQ-010 SHALL emit lanes in ascending index; out_lane equals k.
REQ-011 SHALL hold out_data, out_lane, out_last and out_valid stable while out_valid && !out_ready.
REQ-012 SHALL advance to the next lane on each edge with out_valid && out_ready.
REQ-013 SHALL assert out_last only with the final lane: 15, 3 or 0 per mode.
REQ-014 On the final-lane handshake, SHALL deassert out_valid, return to IDLE and set in_ready on that same edge; minimum per-result cost is lanes+1 cycles.
REQ-015 An in_valid arriving during DRAIN SHALL wait; it is accepted no earlier than the cycle after the final-lane handshake.
REQ-016 On accept with mode 11:
- stay in IDLE with in_ready high
- pulse err_mode for exactly one cycle
- emit no lanes
- leave result_count unchanged
REQ-017 SHALL increment result_count on each legal accept, wrapping 0xFFFF -> 0x0000.
REQ-018 out_ready asserted while out_valid is low SHALL have no effect.

Reset
REQ-019 While nrst is low, SHALL force state IDLE and drive in_ready=0, out_valid=0, out_data=0, out_lane=0, out_last=0, err_mode=0, result_count=0, capture registers=0.
REQ-020 SHALL set in_ready high on the first rising edge after nrst deasserts.
REQ-021 Reset asserted mid-DRAIN SHALL discard remaining lanes immediately (asynchronous); no lane is emitted after reset release.

Structure
REQ-022 SHALL take the following constants from the shared MAC package:
- mode encodings
- lane counts (16/4/1)
- lane widths (8/12/20)
- out_data width 20
- state encodings
REQ-023 SHALL place lane selection and sign extension in one combinational sub-module `rfu_lane_select` (inputs: captured data, mode, lane index; output: 20-bit value).
REQ-024 SHALL keep all state in the parent module; `rfu_lane_select` holds no flops.

Verification
REQ-025 Scenario (8b mode): mode=10, in_data[19:0]=0xFFF38, out_ready=1.
- Expect one lane: out_data=0xFFF38, out_lane=0, out_last=1.
- Expect result_count=1 and in_ready high again two cycles after accept.
REQ-026 Scenario (4b mode): mode=01, lanes {0x7FF, 0x800, 0x001, 0xFFF}.
- Expect out_data 0x007FF, 0xFF800, 0x00001, 0xFFFFF in order.
- Expect out_last only on lane 3.
REQ-027 Scenario (2b mode, backpressure): mode=00, in_data=0x0F0E...0100, out_ready toggling 1/0.
- Expect 16 lanes 0x00..0x0F in order with no loss or duplication.
- Expect out_data held stable while out_ready=0.
REQ-028 Scenario (illegal mode): mode=11 accepted.
- Expect err_mode high exactly one cycle, out_valid never high, result_count unchanged.
- Expect an immediate next legal result accepted normally.
REQ-029 Scenario (reset/wrap): assert nrst low during lane 5 of a 2b result.
- Expect all outputs 0 immediately and in_ready=1 one edge after release.
- Separately, 65536 legal accepts wrap result_count to 0.
